// File: rtl/rv_hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_hazard_pkg
// Description : Shared types and constants for the hazard unit and the
//               forwarding unit of the 5-stage RISC-V-lite core.
// Revision    : 1.0  initial release
// ============================================================================
package rv_hazard_pkg;

  // Default register-index width (32 architectural registers)
  localparam int REG_ADDR_W_DFLT = 5;

  // Hazard controller states
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TIMEOUT  = 2'd2
  } hz_state_e;

endpackage
`default_nettype wire

// File: rtl/hazard_unit_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that increments on inc and holds at all-ones.
// Revision    : 1.0  initial release
// ============================================================================
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;

  // Next count: step up unless already saturated
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_unit
// Description : Load-use / taken-branch / data-memory-wait hazard controller
//               with a memory-wait watchdog. Define HAZARD_PERF_EN to build
//               the three saturating performance counters.
// Revision    : 1.0  initial release
// ============================================================================
module hazard_unit
  import rv_hazard_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DFLT,
  parameter int MAX_WAIT   = 15,
  parameter int PERF_CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_use_src1,
  input  logic                  id_use_src2,
  input  logic [REG_ADDR_W-1:0] ex_dest,
  input  logic                  ex_mem_read,
  input  logic                  ex_reg_write,
  input  logic                  ex_branch_taken,
  input  logic                  dmem_req,
  input  logic                  dmem_ready,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic                  ex_mem_hold,
  output logic                  mem_wb_bubble,
  output logic                  mem_timeout
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] lu_stall_cnt,
  output logic [PERF_CNT_W-1:0] mem_stall_cnt,
  output logic [PERF_CNT_W-1:0] flush_cnt
`endif
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  hz_state_e       state_d, state_q;
  logic [WAIT_W-1:0] wait_cnt_d, wait_cnt_q;
  logic            mem_timeout_d, mem_timeout_q;

  logic mem_busy;
  logic load_use;
  logic freeze;

  // Hazard conditions derived from the current inputs
  always_comb begin
    mem_busy = dmem_req & ~dmem_ready;
    load_use = ex_mem_read & ex_reg_write & (ex_dest != '0) &
               ((id_use_src1 & (id_src1 == ex_dest)) |
                (id_use_src2 & (id_src2 == ex_dest)));
    freeze   = (state_q == TIMEOUT) | mem_busy;
  end

  // Next state and watchdog counter
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    case (state_q)
      RUN: begin
        if (mem_busy) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (!mem_busy) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LIMIT) begin
          state_d    = TIMEOUT;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      TIMEOUT: begin
        // Only reset leaves this state
        state_d = TIMEOUT;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
    mem_timeout_d = mem_timeout_q | (state_d == TIMEOUT);
  end

  // State, watchdog and sticky timeout registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  // Pipeline controls in priority order: reset, freeze, branch, load-use, normal
  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_hold   = 1'b0;
    mem_wb_bubble = 1'b0;
    if (rst) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_bubble  = 1'b1;
      mem_wb_bubble = 1'b1;
    end else if (freeze) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      ex_mem_hold   = 1'b1;
      mem_wb_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      // IF/ID stays enabled so the flushed NOP is captured
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
    end else if (load_use) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_bubble  = 1'b1;
    end
  end

  assign mem_timeout = mem_timeout_q;

`ifdef HAZARD_PERF_EN
  logic act_branch;
  logic act_lu;

  // Only the hazard that actually drove the controls is counted
  always_comb begin
    act_branch = ~freeze & ex_branch_taken;
    act_lu     = ~freeze & ~ex_branch_taken & load_use;
  end

  sat_counter #(.WIDTH(PERF_CNT_W)) u_lu_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (act_lu),
    .count (lu_stall_cnt)
  );

  sat_counter #(.WIDTH(PERF_CNT_W)) u_mem_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (freeze),
    .count (mem_stall_cnt)
  );

  sat_counter #(.WIDTH(PERF_CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (act_branch),
    .count (flush_cnt)
  );
`else
  // Counter width is only meaningful when the counters are built
  if (PERF_CNT_W < 1) begin : g_perf_w_unused
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_unit
// Description : Self-checking bench for hazard_unit against a cycle-level
//               behavioural model (freeze run length + timed-out flag).
// Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_unit;

  localparam int MAX_WAIT   = 15;
  localparam int PERF_CNT_W = 32;
  localparam int RW         = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [RW-1:0] id_src1, id_src2, ex_dest;
  logic          id_use_src1, id_use_src2;
  logic          ex_mem_read, ex_reg_write, ex_branch_taken;
  logic          dmem_req, dmem_ready;
  logic          pc_write, if_id_write, if_id_flush, id_ex_bubble;
  logic          ex_mem_hold, mem_wb_bubble, mem_timeout;
`ifdef HAZARD_PERF_EN
  logic [PERF_CNT_W-1:0] lu_stall_cnt, mem_stall_cnt, flush_cnt;
`endif

  logic [6:0] outs;
  assign outs = {pc_write, if_id_write, if_id_flush, id_ex_bubble,
                 ex_mem_hold, mem_wb_bubble, mem_timeout};

  // Output vector encodings {pc_w, ifid_w, flush, bubble, hold, wb_bubble, tmo}
  localparam logic [6:0] O_RESET  = 7'b0001010;
  localparam logic [6:0] O_NORMAL = 7'b1100000;
  localparam logic [6:0] O_FREEZE = 7'b0000110;
  localparam logic [6:0] O_TMO    = 7'b0000111;
  localparam logic [6:0] O_BRANCH = 7'b1111000;
  localparam logic [6:0] O_LU     = 7'b0001000;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int     m_run;
  bit     m_timed;
  longint m_lu, m_mem, m_fl;

  hazard_unit #(
    .REG_ADDR_W (RW),
    .MAX_WAIT   (MAX_WAIT),
    .PERF_CNT_W (PERF_CNT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .id_src1         (id_src1),
    .id_src2         (id_src2),
    .id_use_src1     (id_use_src1),
    .id_use_src2     (id_use_src2),
    .ex_dest         (ex_dest),
    .ex_mem_read     (ex_mem_read),
    .ex_reg_write    (ex_reg_write),
    .ex_branch_taken (ex_branch_taken),
    .dmem_req        (dmem_req),
    .dmem_ready      (dmem_ready),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .if_id_flush     (if_id_flush),
    .id_ex_bubble    (id_ex_bubble),
    .ex_mem_hold     (ex_mem_hold),
    .mem_wb_bubble   (mem_wb_bubble),
    .mem_timeout     (mem_timeout)
`ifdef HAZARD_PERF_EN
    ,
    .lu_stall_cnt    (lu_stall_cnt),
    .mem_stall_cnt   (mem_stall_cnt),
    .flush_cnt       (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic bit m_load_use();
    return ex_mem_read && ex_reg_write && (ex_dest != 0) &&
           ((id_use_src1 && id_src1 == ex_dest) ||
            (id_use_src2 && id_src2 == ex_dest));
  endfunction

  function automatic logic [6:0] exp_outs();
    if (rst)                          return O_RESET;
    if (m_timed)                      return O_TMO;
    if (dmem_req && !dmem_ready)      return O_FREEZE;
    if (ex_branch_taken)              return O_BRANCH;
    if (m_load_use())                 return O_LU;
    return O_NORMAL;
  endfunction

  task automatic model_reset();
    m_run = 0; m_timed = 0; m_lu = 0; m_mem = 0; m_fl = 0;
  endtask

  // Advance one clock edge and update the model from the inputs sampled there
  task automatic tick();
    bit busy;
    @(posedge clk);
    busy = dmem_req && !dmem_ready;
    if (rst) begin
      model_reset();
    end else if (m_timed) begin
      m_mem++;
    end else if (busy) begin
      m_mem++;
      m_run++;
      if (m_run > MAX_WAIT) m_timed = 1;
    end else begin
      m_run = 0;
      if (ex_branch_taken) m_fl++;
      else if (m_load_use()) m_lu++;
    end
    #1;
  endtask

  task automatic idle_inputs();
    id_src1 = '0; id_src2 = '0; ex_dest = '0;
    id_use_src1 = 0; id_use_src2 = 0;
    ex_mem_read = 0; ex_reg_write = 0; ex_branch_taken = 0;
    dmem_req = 0; dmem_ready = 0;
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    model_reset();
    #2;
    checks++;
    if (outs !== O_RESET) begin
      errors++; $display("FAIL reset_outs: got=%b want=%b", outs, O_RESET);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #2;
    checks++;
    if (outs !== O_NORMAL) begin
      errors++; $display("FAIL reset_release: got=%b want=%b", outs, O_NORMAL);
    end
`ifdef HAZARD_PERF_EN
    checks++;
    if (lu_stall_cnt !== 0 || mem_stall_cnt !== 0 || flush_cnt !== 0) begin
      errors++; $display("FAIL reset_cnt: got=%0d/%0d/%0d want=0/0/0",
                         lu_stall_cnt, mem_stall_cnt, flush_cnt);
    end
`endif
    tick();
  endtask

  task automatic test_load_use();
    idle_inputs();
    ex_mem_read = 1; ex_reg_write = 1; ex_dest = 5'd5;
    id_src1 = 5'd5; id_use_src1 = 1;
    #3;
    checks++;
    if (outs !== O_LU) begin
      errors++; $display("FAIL load_use_stall: got=%b want=%b", outs, O_LU);
    end
    tick();
    // Bubble now in EX: condition gone
    ex_mem_read = 0; ex_reg_write = 0; ex_dest = '0;
    #3;
    checks++;
    if (outs !== O_NORMAL) begin
      errors++; $display("FAIL load_use_release: got=%b want=%b", outs, O_NORMAL);
    end
`ifdef HAZARD_PERF_EN
    checks++;
    if (lu_stall_cnt !== PERF_CNT_W'(m_lu)) begin
      errors++; $display("FAIL load_use_cnt: got=%0d want=%0d", lu_stall_cnt, m_lu);
    end
`endif
    tick();
  endtask

  task automatic test_x0_load();
    idle_inputs();
    ex_mem_read = 1; ex_reg_write = 1; ex_dest = '0;
    id_src1 = '0; id_use_src1 = 1; id_src2 = '0; id_use_src2 = 1;
    #3;
    checks++;
    if (outs !== O_NORMAL) begin
      errors++; $display("FAIL x0_load: got=%b want=%b", outs, O_NORMAL);
    end
    tick();
  endtask

  task automatic test_branch_lu();
    idle_inputs();
    ex_mem_read = 1; ex_reg_write = 1; ex_dest = 5'd9;
    id_src2 = 5'd9; id_use_src2 = 1; ex_branch_taken = 1;
    #3;
    checks++;
    if (outs !== O_BRANCH) begin
      errors++; $display("FAIL branch_lu: got=%b want=%b", outs, O_BRANCH);
    end
    tick();
    idle_inputs();
    #3;
`ifdef HAZARD_PERF_EN
    checks++;
    if (flush_cnt !== PERF_CNT_W'(m_fl) || lu_stall_cnt !== PERF_CNT_W'(m_lu)) begin
      errors++; $display("FAIL branch_cnt: got=%0d/%0d want=%0d/%0d",
                         flush_cnt, lu_stall_cnt, m_fl, m_lu);
    end
`endif
    tick();
  endtask

  task automatic test_short_wait();
    idle_inputs();
    dmem_req = 1; dmem_ready = 0;
    ex_branch_taken = 1;  // held branch must not act during a freeze
    for (int i = 0; i < 3; i++) begin
      #3;
      checks++;
      if (outs !== O_FREEZE) begin
        errors++; $display("FAIL short_wait_freeze[%0d]: got=%b want=%b", i, outs, O_FREEZE);
      end
      tick();
    end
    dmem_ready = 1;
    #3;
    checks++;
    if (outs !== O_BRANCH) begin
      errors++; $display("FAIL short_wait_release: got=%b want=%b", outs, O_BRANCH);
    end
    tick();
    idle_inputs();
    #3;
    checks++;
    if (outs !== O_NORMAL) begin
      errors++; $display("FAIL short_wait_run: got=%b want=%b", outs, O_NORMAL);
    end
`ifdef HAZARD_PERF_EN
    checks++;
    if (mem_stall_cnt !== PERF_CNT_W'(m_mem)) begin
      errors++; $display("FAIL short_wait_cnt: got=%0d want=%0d", mem_stall_cnt, m_mem);
    end
`endif
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      id_src1         = RW'($urandom_range(0, 3));
      id_src2         = RW'($urandom_range(0, 3));
      ex_dest         = RW'($urandom_range(0, 3));
      id_use_src1     = 1'($urandom_range(0, 1));
      id_use_src2     = 1'($urandom_range(0, 1));
      ex_mem_read     = 1'($urandom_range(0, 1));
      ex_reg_write    = ($urandom_range(0, 3) != 0);
      ex_branch_taken = ($urandom_range(0, 3) == 0);
      dmem_req        = ($urandom_range(0, 3) == 0);
      dmem_ready      = 1'($urandom_range(0, 1));
      #3;
      checks++;
      if (outs !== exp_outs()) begin
        errors++; $display("FAIL random[%0d]: got=%b want=%b", i, outs, exp_outs());
      end
`ifdef HAZARD_PERF_EN
      checks++;
      if (lu_stall_cnt !== PERF_CNT_W'(m_lu) || mem_stall_cnt !== PERF_CNT_W'(m_mem) ||
          flush_cnt !== PERF_CNT_W'(m_fl)) begin
        errors++; $display("FAIL random_cnt[%0d]: got=%0d/%0d/%0d want=%0d/%0d/%0d", i,
                           lu_stall_cnt, mem_stall_cnt, flush_cnt, m_lu, m_mem, m_fl);
      end
`endif
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_timeout();
    idle_inputs();
    pulse_reset();
    dmem_req = 1; dmem_ready = 0;
    for (int i = 0; i < MAX_WAIT + 1; i++) begin
      #3;
      checks++;
      if (outs !== O_FREEZE) begin
        errors++; $display("FAIL timeout_freeze[%0d]: got=%b want=%b", i, outs, O_FREEZE);
      end
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      dmem_ready = (i != 0);
      dmem_req   = (i < 2);
      #3;
      checks++;
      if (outs !== O_TMO) begin
        errors++; $display("FAIL timeout_sticky[%0d]: got=%b want=%b", i, outs, O_TMO);
      end
      tick();
    end
    idle_inputs();
    pulse_reset();
    #2;
    checks++;
    if (outs !== O_NORMAL) begin
      errors++; $display("FAIL timeout_cleared: got=%b want=%b", outs, O_NORMAL);
    end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    idle_inputs();
    dmem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 7; i++) tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (outs !== O_RESET) begin
      errors++; $display("FAIL midwait_reset_outs: got=%b want=%b", outs, O_RESET);
    end
`ifdef HAZARD_PERF_EN
    checks++;
    if (lu_stall_cnt !== 0 || mem_stall_cnt !== 0 || flush_cnt !== 0) begin
      errors++; $display("FAIL midwait_reset_cnt: got=%0d/%0d/%0d want=0/0/0",
                         lu_stall_cnt, mem_stall_cnt, flush_cnt);
    end
`endif
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    // A fresh full-length wait must again get MAX_WAIT+1 freeze cycles
    for (int i = 0; i < MAX_WAIT + 2; i++) begin
      #3;
      checks++;
      if (outs !== exp_outs()) begin
        errors++; $display("FAIL midwait_rewait[%0d]: got=%b want=%b", i, outs, exp_outs());
      end
      tick();
    end
    idle_inputs();
    pulse_reset();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_x0_load();
    test_branch_lu();
    test_short_wait();
    test_random();
    test_timeout();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
